// File: rtl/alu_ctrl_stage.sv
// ALU control stage: encodes ALUOp/Funct3/Funct7/RType into an ALU operation code and
// buffers it in a 2-entry valid/ready FIFO. Optional ALU_CTRL_ILLEGAL_CNT_EN adds IllegalCount.
module alu_ctrl_stage #(
    parameter int unsigned OPCODE_LENGTH = 4,
    parameter int unsigned DEPTH         = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic                     RType,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     OpIllegal
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    ,
    output logic [15:0]              IllegalCount
`endif
);

    logic [OPCODE_LENGTH-1:0] enc_op;
    logic                     enc_ill;
    logic [OPCODE_LENGTH-1:0] op_q [2];
    logic                     ill_q [2];
    logic                     wr_ptr_q, rd_ptr_q;
    logic [1:0]               count_q;
    logic                     rdy_q;
    logic                     push, pop;

    always_comb begin
        enc_op  = '0;
        enc_ill = 1'b0;
        unique case (ALUOp)
            2'b00: enc_op = OPCODE_LENGTH'(4'b0010);
            2'b01: begin
                case (Funct3)
                    3'b000:  enc_op = OPCODE_LENGTH'(4'b1000);
                    3'b001:  enc_op = OPCODE_LENGTH'(4'b1010);
                    default: enc_ill = 1'b1;
                endcase
            end
            2'b10: begin
                case (Funct3)
                    3'b000:  enc_op = (RType & Funct7[5]) ? OPCODE_LENGTH'(4'b0011)
                                                          : OPCODE_LENGTH'(4'b0010);
                    3'b111:  enc_op = OPCODE_LENGTH'(4'b0000);
                    3'b110:  enc_op = OPCODE_LENGTH'(4'b0001);
                    3'b100:  enc_op = OPCODE_LENGTH'(4'b0100);
                    3'b001: begin
                        enc_op  = OPCODE_LENGTH'(4'b0110);
                        enc_ill = (Funct7 != 7'd0);
                    end
                    default: enc_ill = 1'b1;
                endcase
            end
            default: enc_op = OPCODE_LENGTH'(4'b1001);
        endcase
    end

    // rdy_q keeps in_ready low during reset and until the first clock after release
    assign in_ready  = rdy_q & (count_q < 2'(DEPTH));
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign Operation = out_valid ? op_q[rd_ptr_q] : '0;
    assign OpIllegal = out_valid & ill_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q    <= 1'b0;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            op_q[0]  <= '0;
            op_q[1]  <= '0;
            ill_q[0] <= 1'b0;
            ill_q[1] <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (flush) begin
                count_q  <= 2'd0;
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                if (push) begin
                    op_q[wr_ptr_q]  <= enc_op;
                    ill_q[wr_ptr_q] <= enc_ill;
                    wr_ptr_q        <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + 2'd1;
                    2'b01:   count_q <= count_q - 2'd1;
                    default: ;
                endcase
            end
        end
    end

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    // Counts accepted illegal entries even when a same-cycle flush drops them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IllegalCount <= 16'd0;
        end else if (push && enc_ill && (IllegalCount != 16'hFFFF)) begin
            IllegalCount <= IllegalCount + 16'd1;
        end
    end
`endif

endmodule
